// File: rtl/clock_pkg.sv
// Shared definitions for the clock chain (seconds, minutes, hours stages).
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned HOURS_24_MAX = 23;
  localparam int unsigned HOURS_12_MAX = 12;

  // Binary 0..23 to packed {tens, units} BCD.
  function automatic logic [7:0] to_bcd(input int unsigned v);
    bcd_digit_t t;
    bcd_digit_t u;
    t = bcd_digit_t'(v / 10);
    u = bcd_digit_t'(v % 10);
    return {t, u};
  endfunction

endpackage

// File: rtl/counter_hours_adjust_pacer.sv
// Key-repeat pacer for the set-mode adjust keys: produces single-cycle
// inc/dec step pulses, the first on the opening cycle of a single-key
// press, then one every ADJ_DIV cycles while that key stays held.
module adjust_pacer #(
  parameter int unsigned ADJ_DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_up,
  input  logic i_down,
  input  logic i_mode,
  output logic o_inc_step,
  output logic o_dec_step
);

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DOWN = 2'd2;

  localparam int unsigned DIV_EFF  = (ADJ_DIV < 1) ? 1 : ((ADJ_DIV > 255) ? 255 : ADJ_DIV);
  localparam logic [7:0]  DIV_LAST = 8'(DIV_EFF - 1);

  logic [1:0] w_dir;
  logic [1:0] r_dir;
  logic [7:0] r_cnt;
  logic       w_active;
  logic       w_fire;

  // Decode the requested direction; only a single key in set mode counts.
  // r_dir is NONE in run mode, so entering set mode with a key held or
  // flipping direction both look like a fresh press and restart pacing.
  always_comb begin
    w_dir = DIR_NONE;
    if (!i_mode) begin
      if (i_up && !i_down)      w_dir = DIR_UP;
      else if (i_down && !i_up) w_dir = DIR_DOWN;
    end
    w_active   = (w_dir != DIR_NONE);
    w_fire     = w_active && ((w_dir != r_dir) || (r_cnt == DIV_LAST));
    o_inc_step = w_fire && (w_dir == DIR_UP);
    o_dec_step = w_fire && (w_dir == DIR_DOWN);
  end

  // Prescaler counts cycles since the last step and clears whenever idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dir <= DIR_NONE;
      r_cnt <= '0;
    end else begin
      r_dir <= w_dir;
      if (!w_active || w_fire) r_cnt <= '0;
      else                     r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/counter_hours.sv
// Hours stage of the clock chain: BCD hour register with run-mode counting
// on tick_hour, set-mode up/down adjust, and a registered tick_day pulse.
// Build option: define HOUR_FORMAT_12H_EN for 12h operation with a pm port.
module counter_hours
  import clock_pkg::*;
#(
  parameter int unsigned ADJ_DIV    = 1,
  parameter int unsigned RESET_HOUR = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_hour,
  input  logic       tick_hour,
  input  logic       up,
  input  logic       down,
  output logic [3:0] hour_unit,
  output logic [3:0] hour_ten,
  output logic       tick_day
`ifdef HOUR_FORMAT_12H_EN
  ,
  output logic       pm
`endif
);

`ifdef HOUR_FORMAT_12H_EN
  localparam int unsigned RST_H = ((RESET_HOUR >= 1) && (RESET_HOUR <= HOURS_12_MAX))
                                  ? RESET_HOUR : HOURS_12_MAX;
`else
  localparam int unsigned RST_H = (RESET_HOUR <= HOURS_24_MAX) ? RESET_HOUR : 0;
`endif
  localparam logic [7:0] RST_BCD = to_bcd(RST_H);

  bcd_digit_t r_ten;
  bcd_digit_t r_unit;
  logic       r_tick_day;
  bcd_digit_t w_ten_nx;
  bcd_digit_t w_unit_nx;
  logic       w_day;
  logic       w_inc_step;
  logic       w_dec_step;
  logic       w_inc;
  logic       w_dec;
`ifdef HOUR_FORMAT_12H_EN
  logic       r_pm;
  logic       w_pm_nx;
`endif

  adjust_pacer #(
    .ADJ_DIV(ADJ_DIV)
  ) u_pacer (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_up       (up),
    .i_down     (down),
    .i_mode     (mode_hour),
    .o_inc_step (w_inc_step),
    .o_dec_step (w_dec_step)
  );

  // Next-hour computation: increment/decrement with BCD carry and wrap.
  always_comb begin
    w_inc     = mode_hour ? tick_hour : w_inc_step;
    w_dec     = !mode_hour && w_dec_step;
    w_ten_nx  = r_ten;
    w_unit_nx = r_unit;
    w_day     = 1'b0;
`ifdef HOUR_FORMAT_12H_EN
    w_pm_nx   = r_pm;
    w_day     = mode_hour && tick_hour && r_pm && (r_ten == 4'd1) && (r_unit == 4'd1);
    if (w_inc) begin
      if ((r_ten == 4'd1) && (r_unit == 4'd2)) begin
        w_ten_nx  = 4'd0;
        w_unit_nx = 4'd1;
      end else if ((r_ten == 4'd1) && (r_unit == 4'd1)) begin
        w_unit_nx = 4'd2;
        w_pm_nx   = !r_pm;
      end else if (r_unit >= 4'd9) begin
        w_ten_nx  = 4'd1;
        w_unit_nx = 4'd0;
      end else begin
        w_unit_nx = r_unit + 4'd1;
      end
    end else if (w_dec) begin
      if ((r_ten == 4'd0) && (r_unit <= 4'd1)) begin
        w_ten_nx  = 4'd1;
        w_unit_nx = 4'd2;
      end else if ((r_ten == 4'd1) && (r_unit == 4'd2)) begin
        w_unit_nx = 4'd1;
        w_pm_nx   = !r_pm;
      end else if (r_unit == 4'd0) begin
        w_ten_nx  = 4'd0;
        w_unit_nx = 4'd9;
      end else begin
        w_unit_nx = r_unit - 4'd1;
      end
    end
`else
    w_day = mode_hour && tick_hour && (r_ten == 4'd2) && (r_unit == 4'd3);
    if (w_inc) begin
      if ((r_ten >= 4'd2) && (r_unit >= 4'd3)) begin
        w_ten_nx  = 4'd0;
        w_unit_nx = 4'd0;
      end else if (r_unit >= 4'd9) begin
        w_ten_nx  = r_ten + 4'd1;
        w_unit_nx = 4'd0;
      end else begin
        w_unit_nx = r_unit + 4'd1;
      end
    end else if (w_dec) begin
      if ((r_ten == 4'd0) && (r_unit == 4'd0)) begin
        w_ten_nx  = 4'd2;
        w_unit_nx = 4'd3;
      end else if (r_unit == 4'd0) begin
        w_ten_nx  = r_ten - 4'd1;
        w_unit_nx = 4'd9;
      end else begin
        w_unit_nx = r_unit - 4'd1;
      end
    end
`endif
  end

  // Hour register and day-rollover pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ten      <= RST_BCD[7:4];
      r_unit     <= RST_BCD[3:0];
      r_tick_day <= 1'b0;
`ifdef HOUR_FORMAT_12H_EN
      r_pm       <= 1'b0;
`endif
    end else begin
      r_ten      <= w_ten_nx;
      r_unit     <= w_unit_nx;
      r_tick_day <= w_day;
`ifdef HOUR_FORMAT_12H_EN
      r_pm       <= w_pm_nx;
`endif
    end
  end

  assign hour_ten  = r_ten;
  assign hour_unit = r_unit;
  assign tick_day  = r_tick_day;
`ifdef HOUR_FORMAT_12H_EN
  assign pm        = r_pm;
`endif

endmodule
